rsa_link_host: RTL and testbench

- Host-side (initiator) end of the RSA UART link; mirror of the FPGA-side receive/compute/transmit path.
- Takes one request (exponent e, modulus n, message m) in parallel and streams it as a byte frame through the uart transmit handshake.
- Collects the BITLEN/8-byte response and presents it as a parallel answer.
- Used as loopback driver in system benches and in a two-board host build.

---
 rtl/rsa_link_host.sv | 164 ++++++++++++++++
 tb/tb_rsa_link_host.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_link_host.sv
// Host-side RSA link initiator: streams {e,n,m} out over a uart byte handshake and gathers the NB-byte answer.
// Latency: first transmit strobe 2 cycles after an accepted start; done one cycle after the last good rx byte.
// Backpressure: each byte waits for is_transmitting low, then a guard cycle, then waits for the uart to go idle again.
// Optional response timeout is compiled in with `define RSA_LINK_TIMEOUT_EN.
module rsa_link_host #(
    parameter int BITLEN         = 64,
    parameter int TIMEOUT_CYCLES = 24000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [BITLEN-1:0] op_e,
    input  logic [BITLEN-1:0] op_n,
    input  logic [BITLEN-1:0] op_m,
    output logic              busy,
    output logic              done,
    output logic [BITLEN-1:0] ans,
    output logic              err,
    output logic [7:0]        tx_byte,
    output logic              transmit,
    input  logic              is_transmitting,
    input  logic [7:0]        rx_byte,
    input  logic              received,
    input  logic              recv_error
);

    localparam int NB    = BITLEN / 8;
    localparam int FRAME = 3 * NB;
    localparam int TXW   = $clog2(FRAME + 1);
    localparam int RXW   = $clog2(NB + 1);

    // Reject parameter sets the byte framing cannot represent.
    if ((BITLEN % 8) != 0 || BITLEN < 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("rsa_link_host: BITLEN must be a positive multiple of 8 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SEND     = 3'd1,
        S_TX_GUARD = 3'd2,
        S_TX_WAIT  = 3'd3,
        S_RECV     = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [3*BITLEN-1:0] shreg;
    logic [TXW-1:0]      tx_cnt;
    logic [RXW-1:0]      rx_cnt;
    logic                good_byte;
    logic                last_rx;
    logic                frame_sent;
    logic                timeout;

    assign good_byte  = (state == S_RECV) && received && !recv_error;
    assign last_rx    = good_byte && (rx_cnt == RXW'(NB - 1));
    assign frame_sent = (tx_cnt >= TXW'(FRAME));

`ifdef RSA_LINK_TIMEOUT_EN
    localparam int TMW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMW-1:0] timer;

    // A good byte in the same cycle takes priority over the timeout.
    assign timeout = (state == S_RECV) && !good_byte && (timer == TMW'(TIMEOUT_CYCLES - 1));

    // Response watchdog: counts RECV cycles since entry or since the last good byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer <= '0;
        end else if (state != S_RECV || good_byte) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: send every frame byte through the guarded handshake, then collect the answer.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:     if (start) state_nxt = S_SEND;
            S_SEND:     if (!is_transmitting) state_nxt = S_TX_GUARD;
            S_TX_GUARD: state_nxt = S_TX_WAIT;
            S_TX_WAIT:  if (!is_transmitting) state_nxt = frame_sent ? S_RECV : S_SEND;
            S_RECV:     if (last_rx || timeout) state_nxt = S_DONE;
            S_DONE:     state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // Status outputs decoded from the state; DONE is the only cycle with done high and busy low together.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state)
            S_SEND, S_TX_GUARD, S_TX_WAIT, S_RECV: busy = 1'b1;
            S_DONE:                                done = 1'b1;
            default:                               ;
        endcase
    end

    // Datapath: frame shift register, byte strobe, counters, answer assembly and sticky error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg    <= '0;
            tx_byte  <= '0;
            transmit <= 1'b0;
            tx_cnt   <= '0;
            rx_cnt   <= '0;
            ans      <= '0;
            err      <= 1'b0;
        end else begin
            transmit <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        shreg  <= {op_m, op_n, op_e};
                        tx_cnt <= '0;
                        err    <= 1'b0;
                    end
                end
                S_SEND: begin
                    if (!is_transmitting) begin
                        tx_byte  <= shreg[7:0];
                        transmit <= 1'b1;
                        shreg    <= shreg >> 8;
                        tx_cnt   <= tx_cnt + 1'b1;
                    end
                end
                S_TX_WAIT: begin
                    if (!is_transmitting && frame_sent) begin
                        rx_cnt <= '0;
                    end
                end
                S_RECV: begin
                    if (received && recv_error) begin
                        err <= 1'b1;
                    end else if (good_byte) begin
                        ans    <= {rx_byte, ans[BITLEN-1:8]};
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                    if (timeout) begin
                        err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_link_host.sv
// Directed bench for rsa_link_host: uart transmitter model, frame capture, response injection, reset abort.
// Define RSA_LINK_TIMEOUT_EN for both files to also exercise the response timeout (TIMEOUT_CYCLES=100).
// Expected frames and answers are hand-computed constants.
module tb_rsa_link_host;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [63:0] op_e = '0;
    logic [63:0] op_n = '0;
    logic [63:0] op_m = '0;
    logic        busy;
    logic        done;
    logic [63:0] ans;
    logic        err;
    logic [7:0]  tx_byte;
    logic        transmit;
    logic        is_transmitting = 1'b0;
    logic [7:0]  rx_byte = '0;
    logic        received = 1'b0;
    logic        recv_error = 1'b0;

    int checks = 0;
    int errors = 0;

    rsa_link_host #(.BITLEN(64), .TIMEOUT_CYCLES(100)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .op_e            (op_e),
        .op_n            (op_n),
        .op_m            (op_m),
        .busy            (busy),
        .done            (done),
        .ans             (ans),
        .err             (err),
        .tx_byte         (tx_byte),
        .transmit        (transmit),
        .is_transmitting (is_transmitting),
        .rx_byte         (rx_byte),
        .received        (received),
        .recv_error      (recv_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Uart transmitter model: busy for 6 cycles after each strobe; records bytes and strobes while busy.
    logic [7:0] txq[$];
    int         tx_left = 0;
    int         overlap_cnt = 0;
    always @(negedge clk) begin
        if (transmit) begin
            txq.push_back(tx_byte);
            if (is_transmitting) overlap_cnt++;
            tx_left = 6;
        end else if (tx_left > 0) begin
            tx_left--;
        end
        is_transmitting = (tx_left != 0);
    end

    // Done monitor: counts pulses and flags any done not paired with busy falling in that cycle.
    int   done_cnt = 0;
    int   done_bad = 0;
    logic prev_busy = 1'b0;
    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            if (busy || !prev_busy) done_bad++;
        end
        prev_busy = busy;
    end

    task automatic pulse_start(input logic [63:0] e, input logic [63:0] n, input logic [63:0] m);
        @(negedge clk);
        op_e  = e;
        op_n  = n;
        op_m  = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic e);
        @(negedge clk);
        rx_byte    = b;
        received   = 1'b1;
        recv_error = e;
        @(negedge clk);
        received   = 1'b0;
        recv_error = 1'b0;
    endtask

    task automatic wait_frame(input int n);
        int k = 0;
        while (!(txq.size() >= n && !is_transmitting) && k < 5000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 5000) check("frame_wait_timeout", 0, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_done(input int d0);
        int k = 0;
        while (done_cnt == d0 && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (k >= 500) check("done_wait_timeout", 0, 1);
        #1;
    endtask

    function automatic logic [191:0] captured();
        logic [191:0] v = '0;
        for (int i = 0; i < 24 && i < txq.size(); i++) v[i*8 +: 8] = txq[i];
        return v;
    endfunction

    task automatic feed_answer_1_to_8();
        for (int i = 1; i <= 8; i++) send_rx(8'(8'h11 * i), 1'b0);
    endtask

    initial begin
        int d0;
        int k;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_transmit", transmit, 0);
        check("rst_err", err, 0);
        check("rst_tx_byte", tx_byte, 0);
        check("rst_ans", ans, 0);
        @(negedge clk);
        rst = 1'b1;

        // Receive strobes in IDLE are ignored, even with a framing error
        send_rx(8'hAB, 1'b1);
        #1;
        check("idle_rx_err", err, 0);
        check("idle_rx_ans", ans, 0);

        // Frame A with a start pulse mid-SEND that must be ignored
        txq.delete();
        pulse_start(64'h10001, 64'hC3, 64'h2);
        #1;
        check("lat_busy", busy, 1);
        check("lat_tx_early", transmit, 0);
        @(negedge clk);
        #1;
        check("lat_tx", transmit, 1);
        check("first_byte", tx_byte, 8'h01);
        k = 0;
        while (txq.size() < 5 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        pulse_start(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_frame(24);
        check("a_tx_count", txq.size(), 24);
        check("a_frame", captured(), {64'h2, 64'hC3, 64'h10001});
        check("a_overlap", overlap_cnt, 0);
        d0 = done_cnt;
        feed_answer_1_to_8();
        wait_done(d0);
        check("a_ans", ans, 64'h8877665544332211);
        check("a_err", err, 0);
        repeat (3) @(negedge clk);
        #1;
        check("a_done_once", done_cnt - d0, 1);
        check("a_done_busy", done_bad, 0);
        check("a_busy_after", busy, 0);
        check("a_tx_count_final", txq.size(), 24);

        // Frame B: third rx byte has a framing error
        txq.delete();
        pulse_start(64'h5, 64'h7, 64'h3);
        wait_frame(24);
        check("b_frame", captured(), {64'h3, 64'h7, 64'h5});
        d0 = done_cnt;
        send_rx(8'h11, 1'b0);
        send_rx(8'h22, 1'b0);
        send_rx(8'h33, 1'b1);
        #1;
        check("b_err_set", err, 1);
        check("b_busy_still", busy, 1);
        send_rx(8'h33, 1'b0);
        send_rx(8'h44, 1'b0);
        send_rx(8'h55, 1'b0);
        send_rx(8'h66, 1'b0);
        send_rx(8'h77, 1'b0);
        send_rx(8'h88, 1'b0);
        wait_done(d0);
        check("b_ans", ans, 64'h8877665544332211);
        check("b_err_at_done", err, 1);
        repeat (5) @(negedge clk);
        #1;
        check("b_err_sticky", err, 1);

        // Frame C: reset pulled during the 10th transmit strobe
        txq.delete();
        pulse_start(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'h0F1E_2D3C_4B5A_6978);
        #1;
        check("c_err_cleared", err, 0);
        k = 0;
        while (k < 5000) begin
            @(negedge clk);
            #1;
            if (transmit && txq.size() == 10) break;
            k++;
        end
        check("c_reached_10th", txq.size(), 10);
        rst = 1'b0;
        #1;
        check("c_rst_transmit", transmit, 0);
        check("c_rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b1;
        txq.delete();
        repeat (10) @(negedge clk);
        check("c_no_stray_tx", txq.size(), 0);
        pulse_start(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'h0F1E_2D3C_4B5A_6978);
        wait_frame(24);
        check("c_tx_count", txq.size(), 24);
        check("c_frame", captured(),
              {64'h0F1E_2D3C_4B5A_6978, 64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF});
        d0 = done_cnt;
        feed_answer_1_to_8();
        wait_done(d0);
        check("c_ans", ans, 64'h8877665544332211);

`ifdef RSA_LINK_TIMEOUT_EN
        // Timeout: three good bytes then silence
        txq.delete();
        pulse_start(64'h3, 64'h21, 64'h4);
        wait_frame(24);
        send_rx(8'h11, 1'b0);
        send_rx(8'h22, 1'b0);
        send_rx(8'h33, 1'b0);
        k = 0;
        while (!done && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("to_latency", k, 100);
        #1;
        check("to_done", done, 1);
        check("to_err", err, 1);
        check("to_ans_partial", ans, 64'h3322118877665544);
        @(negedge clk);
        #1;
        check("to_idle", busy, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
